// File: rtl/alu_issue_scheduler.sv
// Issue scheduler for the shared ALU: buffers dispatched ops, snoops ALU/LSB
// result buses for pending operands and issues the lowest-index ready entry.
module alu_issue_scheduler #(
    parameter int ROB_WIDTH = 4,
    parameter int DEPTH     = 8
) (
    input  logic                  clk_in,
    input  logic                  rst_n_in,
    input  logic                  rdy_in,
    input  logic                  clear_signal,
    input  logic                  dis_valid,
    input  logic [3:0]            dis_opcode,
    input  logic                  dis_qj_valid,
    input  logic                  dis_qk_valid,
    input  logic [ROB_WIDTH-1:0]  dis_qj,
    input  logic [ROB_WIDTH-1:0]  dis_qk,
    input  logic [31:0]           dis_vj,
    input  logic [31:0]           dis_vk,
    input  logic [ROB_WIDTH-1:0]  dis_tag,
    output logic                  full,
    output logic [$clog2(DEPTH):0] count,
    input  logic                  alu_done,
    input  logic [31:0]           alu_value,
    input  logic [ROB_WIDTH-1:0]  alu_tag,
    input  logic                  lsb_done,
    input  logic [31:0]           lsb_value,
    input  logic [ROB_WIDTH-1:0]  lsb_tag,
    output logic                  cal_signal,
    output logic [3:0]            opcode,
    output logic [31:0]           lhs,
    output logic [31:0]           rhs,
    output logic [ROB_WIDTH-1:0]  tag
);
    localparam int IDX_W = $clog2(DEPTH);
    localparam int CNT_W = IDX_W + 1;

    // Dispatch handshake: dis_valid is accepted at an edge with rdy_in=1,
    // clear_signal=0 and full=0; a request while full is dropped, so the
    // dispatcher must gate dis_valid with !full itself.
    logic [DEPTH-1:0]     valid_q, valid_d;
    logic [DEPTH-1:0]     qj_valid_q, qj_valid_d, qk_valid_q, qk_valid_d;
    logic [3:0]           ent_op_q [DEPTH];
    logic [3:0]           ent_op_d [DEPTH];
    logic [ROB_WIDTH-1:0] ent_tag_q [DEPTH];
    logic [ROB_WIDTH-1:0] ent_tag_d [DEPTH];
    logic [ROB_WIDTH-1:0] qj_q [DEPTH];
    logic [ROB_WIDTH-1:0] qj_d [DEPTH];
    logic [ROB_WIDTH-1:0] qk_q [DEPTH];
    logic [ROB_WIDTH-1:0] qk_d [DEPTH];
    logic [31:0]          vj_q [DEPTH];
    logic [31:0]          vj_d [DEPTH];
    logic [31:0]          vk_q [DEPTH];
    logic [31:0]          vk_d [DEPTH];

    logic                 cal_q, cal_d;
    logic [3:0]           op_q, op_d;
    logic [31:0]          lhs_q, lhs_d, rhs_q, rhs_d;
    logic [ROB_WIDTH-1:0] tag_q, tag_d;

    logic                 issue_hit, free_hit;
    logic [IDX_W-1:0]     issue_idx, free_idx;
    logic [CNT_W-1:0]     cnt;

    // Returns {still_pending, value}; the ALU bus takes priority over the LSB bus.
    function automatic logic [32:0] snoop(
        input logic pend, input logic [ROB_WIDTH-1:0] q, input logic [31:0] v,
        input logic a_done, input logic [ROB_WIDTH-1:0] a_tag, input logic [31:0] a_val,
        input logic l_done, input logic [ROB_WIDTH-1:0] l_tag, input logic [31:0] l_val);
        if (pend && a_done && q == a_tag) return {1'b0, a_val};
        if (pend && l_done && q == l_tag) return {1'b0, l_val};
        return {pend, v};
    endfunction

    always_comb begin
        issue_hit = 1'b0;
        issue_idx = '0;
        free_hit  = 1'b0;
        free_idx  = '0;
        cnt       = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (valid_q[i] && !qj_valid_q[i] && !qk_valid_q[i] && !issue_hit) begin
                issue_hit = 1'b1;
                issue_idx = IDX_W'(i);
            end
            if (!valid_q[i] && !free_hit) begin
                free_hit = 1'b1;
                free_idx = IDX_W'(i);
            end
            cnt = cnt + CNT_W'(valid_q[i]);
        end
    end

    assign full  = &valid_q;
    assign count = cnt;

    always_comb begin
        valid_d    = valid_q;
        qj_valid_d = qj_valid_q;
        qk_valid_d = qk_valid_q;
        ent_op_d   = ent_op_q;
        ent_tag_d  = ent_tag_q;
        qj_d       = qj_q;
        qk_d       = qk_q;
        vj_d       = vj_q;
        vk_d       = vk_q;
        cal_d      = cal_q;
        op_d       = op_q;
        lhs_d      = lhs_q;
        rhs_d      = rhs_q;
        tag_d      = tag_q;
        if (clear_signal) begin
            valid_d = '0;
            cal_d   = 1'b0;
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                if (valid_q[i]) begin
                    {qj_valid_d[i], vj_d[i]} = snoop(qj_valid_q[i], qj_q[i], vj_q[i],
                        alu_done, alu_tag, alu_value, lsb_done, lsb_tag, lsb_value);
                    {qk_valid_d[i], vk_d[i]} = snoop(qk_valid_q[i], qk_q[i], vk_q[i],
                        alu_done, alu_tag, alu_value, lsb_done, lsb_tag, lsb_value);
                end
            end
            cal_d = issue_hit;
            if (issue_hit) begin
                op_d               = ent_op_q[issue_idx];
                lhs_d              = vj_q[issue_idx];
                rhs_d              = vk_q[issue_idx];
                tag_d              = ent_tag_q[issue_idx];
                valid_d[issue_idx] = 1'b0;
            end
            // free_idx only ever names a slot that was empty before this edge.
            if (dis_valid && free_hit) begin
                valid_d[free_idx]   = 1'b1;
                ent_op_d[free_idx]  = dis_opcode;
                ent_tag_d[free_idx] = dis_tag;
                qj_d[free_idx]      = dis_qj;
                qk_d[free_idx]      = dis_qk;
                {qj_valid_d[free_idx], vj_d[free_idx]} = snoop(dis_qj_valid, dis_qj, dis_vj,
                    alu_done, alu_tag, alu_value, lsb_done, lsb_tag, lsb_value);
                {qk_valid_d[free_idx], vk_d[free_idx]} = snoop(dis_qk_valid, dis_qk, dis_vk,
                    alu_done, alu_tag, alu_value, lsb_done, lsb_tag, lsb_value);
            end
        end
    end

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            valid_q    <= '0;
            qj_valid_q <= '0;
            qk_valid_q <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                ent_op_q[i]  <= '0;
                ent_tag_q[i] <= '0;
                qj_q[i]      <= '0;
                qk_q[i]      <= '0;
                vj_q[i]      <= '0;
                vk_q[i]      <= '0;
            end
            cal_q <= 1'b0;
            op_q  <= '0;
            lhs_q <= '0;
            rhs_q <= '0;
            tag_q <= '0;
        end else if (rdy_in) begin
            valid_q    <= valid_d;
            qj_valid_q <= qj_valid_d;
            qk_valid_q <= qk_valid_d;
            ent_op_q   <= ent_op_d;
            ent_tag_q  <= ent_tag_d;
            qj_q       <= qj_d;
            qk_q       <= qk_d;
            vj_q       <= vj_d;
            vk_q       <= vk_d;
            cal_q      <= cal_d;
            op_q       <= op_d;
            lhs_q      <= lhs_d;
            rhs_q      <= rhs_d;
            tag_q      <= tag_d;
        end
    end

    assign cal_signal = cal_q;
    assign opcode     = op_q;
    assign lhs        = lhs_q;
    assign rhs        = rhs_q;
    assign tag        = tag_q;
endmodule

// File: tb/tb_alu_issue_scheduler.sv
// Self-checking bench for alu_issue_scheduler: scenario tasks with inline
// checks plus an issue monitor that pops a queue of expected issues.
module tb_alu_issue_scheduler;
    logic        clk_in = 1'b0;
    logic        rst_n_in;
    logic        rdy_in;
    logic        clear_signal;
    logic        dis_valid;
    logic [3:0]  dis_opcode;
    logic        dis_qj_valid, dis_qk_valid;
    logic [3:0]  dis_qj, dis_qk;
    logic [31:0] dis_vj, dis_vk;
    logic [3:0]  dis_tag;
    logic        full;
    logic [3:0]  count;
    logic        alu_done;
    logic [31:0] alu_value;
    logic [3:0]  alu_tag;
    logic        lsb_done;
    logic [31:0] lsb_value;
    logic [3:0]  lsb_tag;
    logic        cal_signal;
    logic [3:0]  opcode;
    logic [31:0] lhs, rhs;
    logic [3:0]  tag;

    int checks = 0;
    int errors = 0;
    logic [71:0] exp_q[$];

    alu_issue_scheduler #(.ROB_WIDTH(4), .DEPTH(8)) dut (
        .clk_in(clk_in), .rst_n_in(rst_n_in), .rdy_in(rdy_in), .clear_signal(clear_signal),
        .dis_valid(dis_valid), .dis_opcode(dis_opcode),
        .dis_qj_valid(dis_qj_valid), .dis_qk_valid(dis_qk_valid),
        .dis_qj(dis_qj), .dis_qk(dis_qk), .dis_vj(dis_vj), .dis_vk(dis_vk), .dis_tag(dis_tag),
        .full(full), .count(count),
        .alu_done(alu_done), .alu_value(alu_value), .alu_tag(alu_tag),
        .lsb_done(lsb_done), .lsb_value(lsb_value), .lsb_tag(lsb_tag),
        .cal_signal(cal_signal), .opcode(opcode), .lhs(lhs), .rhs(rhs), .tag(tag)
    );

    // clock / reset
    always #5 clk_in = ~clk_in;

    // issue monitor: an issue is consumed at the edge where cal_signal=1 and rdy_in=1
    always @(negedge clk_in) begin
        if (rst_n_in && rdy_in && cal_signal) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_issue: got op=%0h lhs=%0h rhs=%0h tag=%0h, required no issue",
                         opcode, lhs, rhs, tag);
            end else begin
                logic [71:0] e;
                e = exp_q.pop_front();
                if ({opcode, lhs, rhs, tag} !== e) begin
                    errors++;
                    $display("FAIL issue_data: got op=%0h lhs=%0h rhs=%0h tag=%0h, required op=%0h lhs=%0h rhs=%0h tag=%0h",
                             opcode, lhs, rhs, tag, e[71:68], e[67:36], e[35:4], e[3:0]);
                end
            end
        end
    end

    // driver tasks
    task automatic tick();
        @(posedge clk_in);
        #1;
    endtask

    task automatic idle_inputs();
        dis_valid = 1'b0; clear_signal = 1'b0;
        alu_done = 1'b0; lsb_done = 1'b0;
    endtask

    task automatic drive_dis(input logic [3:0] op, input logic qjv, input logic [3:0] qj,
                             input logic [31:0] vj, input logic qkv, input logic [3:0] qk,
                             input logic [31:0] vk, input logic [3:0] t);
        dis_valid = 1'b1; dis_opcode = op;
        dis_qj_valid = qjv; dis_qj = qj; dis_vj = vj;
        dis_qk_valid = qkv; dis_qk = qk; dis_vk = vk;
        dis_tag = t;
    endtask

    task automatic push_exp(input logic [3:0] op, input logic [31:0] l, input logic [31:0] r,
                            input logic [3:0] t);
        exp_q.push_back({op, l, r, t});
    endtask

    task automatic test_reset();
        #2;
        checks++; if (cal_signal !== 1'b0) begin errors++; $display("FAIL rst_cal: got %0b required 0", cal_signal); end
        checks++; if (count !== 4'd0) begin errors++; $display("FAIL rst_count: got %0d required 0", count); end
        checks++; if (full !== 1'b0) begin errors++; $display("FAIL rst_full: got %0b required 0", full); end
        checks++; if ({opcode, lhs, rhs, tag} !== 72'd0) begin errors++;
            $display("FAIL rst_outs: got op=%0h lhs=%0h rhs=%0h tag=%0h required all 0", opcode, lhs, rhs, tag); end
        #10 rst_n_in = 1'b1;
        tick();
    endtask

    task automatic test_ready_dispatch();
        push_exp(4'd4, 32'd5, 32'd7, 4'd3);
        drive_dis(4'd4, 1'b0, 4'd0, 32'd5, 1'b0, 4'd0, 32'd7, 4'd3);
        tick(); idle_inputs();
        checks++; if (count !== 4'd1 || cal_signal !== 1'b0) begin errors++;
            $display("FAIL rd_edge0: got count=%0d cal=%0b required 1/0", count, cal_signal); end
        tick();
        checks++; if ({cal_signal, opcode, lhs, rhs, tag} !== {1'b1, 4'd4, 32'd5, 32'd7, 4'd3}) begin errors++;
            $display("FAIL rd_issue: got cal=%0b op=%0h lhs=%0h rhs=%0h tag=%0h required 1/4/5/7/3",
                     cal_signal, opcode, lhs, rhs, tag); end
        checks++; if (count !== 4'd0) begin errors++; $display("FAIL rd_count: got %0d required 0", count); end
        tick();
        checks++; if (cal_signal !== 1'b0) begin errors++; $display("FAIL rd_cal_drop: got %0b required 0", cal_signal); end
    endtask

    task automatic test_wakeup();
        // A: pending qj woken by ALU at edge 3 (LSB carries the same tag, ALU must win)
        push_exp(4'd2, 32'h10, 32'd1, 4'd5);
        drive_dis(4'd2, 1'b1, 4'd2, 32'hBAD, 1'b0, 4'd0, 32'd1, 4'd5);
        tick(); idle_inputs();
        alu_done = 1'b1; alu_tag = 4'd4; alu_value = 32'hDEAD;
        tick(); idle_inputs();
        checks++; if (cal_signal !== 1'b0) begin errors++; $display("FAIL wk_no_early: got cal=%0b required 0", cal_signal); end
        tick();
        checks++; if (cal_signal !== 1'b0 || count !== 4'd1) begin errors++;
            $display("FAIL wk_nomatch: got cal=%0b count=%0d required 0/1", cal_signal, count); end
        alu_done = 1'b1; alu_tag = 4'd2; alu_value = 32'h10;
        lsb_done = 1'b1; lsb_tag = 4'd2; lsb_value = 32'h99;
        tick(); idle_inputs();
        checks++; if (cal_signal !== 1'b0) begin errors++; $display("FAIL wk_edge3: got cal=%0b required 0", cal_signal); end
        tick();
        checks++; if ({cal_signal, lhs, rhs} !== {1'b1, 32'h10, 32'd1}) begin errors++;
            $display("FAIL wk_issue: got cal=%0b lhs=%0h rhs=%0h required 1/10/1", cal_signal, lhs, rhs); end
        tick();
        // B: both operands captured from broadcasts on the dispatch edge itself
        push_exp(4'd3, 32'h33, 32'h22, 4'd6);
        drive_dis(4'd3, 1'b1, 4'd7, 32'd0, 1'b1, 4'd6, 32'd0, 4'd6);
        alu_done = 1'b1; alu_tag = 4'd7; alu_value = 32'h33;
        lsb_done = 1'b1; lsb_tag = 4'd6; lsb_value = 32'h22;
        tick(); idle_inputs();
        checks++; if (count !== 4'd1 || cal_signal !== 1'b0) begin errors++;
            $display("FAIL sc_edge0: got count=%0d cal=%0b required 1/0", count, cal_signal); end
        tick();
        checks++; if ({cal_signal, lhs, rhs, tag} !== {1'b1, 32'h33, 32'h22, 4'd6}) begin errors++;
            $display("FAIL sc_issue: got cal=%0b lhs=%0h rhs=%0h tag=%0h required 1/33/22/6", cal_signal, lhs, rhs, tag); end
        tick();
    endtask

    task automatic test_fill_priority();
        logic [3:0]  ops [8];
        logic [31:0] vks [8];
        logic [31:0] rel_val;
        rel_val = $urandom_range(1, 32'h7fff_ffff);
        for (int i = 0; i < 8; i++) begin
            ops[i] = 4'($urandom_range(0, 15));
            vks[i] = $urandom;
            drive_dis(ops[i], 1'b1, 4'd15, $urandom, 1'b0, 4'd0, vks[i], 4'(i));
            tick();
        end
        idle_inputs();
        checks++; if (full !== 1'b1 || count !== 4'd8) begin errors++;
            $display("FAIL fill_full: got full=%0b count=%0d required 1/8", full, count); end
        drive_dis(4'd1, 1'b0, 4'd0, 32'd1, 1'b0, 4'd0, 32'd1, 4'd9);
        tick(); idle_inputs();
        checks++; if (count !== 4'd8 || cal_signal !== 1'b0) begin errors++;
            $display("FAIL fill_drop: got count=%0d cal=%0b required 8/0", count, cal_signal); end
        for (int i = 0; i < 8; i++) push_exp(ops[i], rel_val, vks[i], 4'(i));
        alu_done = 1'b1; alu_tag = 4'd15; alu_value = rel_val;
        tick(); idle_inputs();
        checks++; if (cal_signal !== 1'b0) begin errors++; $display("FAIL fill_release: got cal=%0b required 0", cal_signal); end
        for (int i = 0; i < 8; i++) begin
            tick();
            checks++; if (cal_signal !== 1'b1 || tag !== 4'(i) || count !== 4'(7 - i)) begin errors++;
                $display("FAIL fill_order%0d: got cal=%0b tag=%0d count=%0d required 1/%0d/%0d",
                         i, cal_signal, tag, count, i, 7 - i); end
            if (i == 0) begin
                checks++; if (full !== 1'b0) begin errors++; $display("FAIL fill_unfull: got %0b required 0", full); end
            end
        end
        tick();
        checks++; if (cal_signal !== 1'b0) begin errors++; $display("FAIL fill_end: got cal=%0b required 0", cal_signal); end
    endtask

    task automatic test_flush();
        drive_dis(4'd5, 1'b1, 4'd14, 32'd0, 1'b0, 4'd0, 32'd0, 4'd1); tick();
        drive_dis(4'd6, 1'b0, 4'd0, 32'd0, 1'b1, 4'd14, 32'd0, 4'd2); tick();
        drive_dis(4'd7, 1'b0, 4'd0, 32'd8, 1'b0, 4'd0, 32'd9, 4'd3); tick();
        idle_inputs();
        checks++; if (count !== 4'd3) begin errors++; $display("FAIL fl_pre: got count=%0d required 3", count); end
        clear_signal = 1'b1;
        drive_dis(4'd8, 1'b0, 4'd0, 32'd1, 1'b0, 4'd0, 32'd1, 4'd4);
        tick(); idle_inputs();
        checks++; if (count !== 4'd0 || cal_signal !== 1'b0 || full !== 1'b0) begin errors++;
            $display("FAIL fl_clear: got count=%0d cal=%0b full=%0b required 0/0/0", count, cal_signal, full); end
        push_exp(4'd0, 32'h44, 32'h55, 4'd10);
        drive_dis(4'd0, 1'b0, 4'd0, 32'h44, 1'b0, 4'd0, 32'h55, 4'd10);
        alu_done = 1'b1; alu_tag = 4'd14; alu_value = 32'h1;
        tick(); idle_inputs();
        checks++; if (count !== 4'd1 || cal_signal !== 1'b0) begin errors++;
            $display("FAIL fl_redis: got count=%0d cal=%0b required 1/0", count, cal_signal); end
        tick();
        checks++; if (cal_signal !== 1'b1 || tag !== 4'd10 || count !== 4'd0) begin errors++;
            $display("FAIL fl_issue: got cal=%0b tag=%0d count=%0d required 1/10/0", cal_signal, tag, count); end
        tick();
    endtask

    task automatic test_stall();
        drive_dis(4'd9, 1'b1, 4'd13, 32'd0, 1'b0, 4'd0, 32'h3, 4'd7); tick();
        push_exp(4'd10, 32'h11, 32'h12, 4'd1);
        drive_dis(4'd10, 1'b0, 4'd0, 32'h11, 1'b0, 4'd0, 32'h12, 4'd1); tick();
        push_exp(4'd11, 32'h21, 32'h22, 4'd2);
        drive_dis(4'd11, 1'b0, 4'd0, 32'h21, 1'b0, 4'd0, 32'h22, 4'd2); tick();
        idle_inputs();
        rdy_in = 1'b0;
        checks++; if (cal_signal !== 1'b1 || tag !== 4'd1) begin errors++;
            $display("FAIL st_pre: got cal=%0b tag=%0d required 1/1", cal_signal, tag); end
        alu_done = 1'b1; alu_tag = 4'd13; alu_value = 32'h77;
        drive_dis(4'd12, 1'b0, 4'd0, 32'd0, 1'b0, 4'd0, 32'd0, 4'd12);
        for (int i = 0; i < 4; i++) begin
            tick();
            checks++; if ({cal_signal, tag, lhs, count} !== {1'b1, 4'd1, 32'h11, 4'd2}) begin errors++;
                $display("FAIL st_hold%0d: got cal=%0b tag=%0d lhs=%0h count=%0d required 1/1/11/2",
                         i, cal_signal, tag, lhs, count); end
        end
        idle_inputs();
        rdy_in = 1'b1;
        tick();
        checks++; if (cal_signal !== 1'b1 || tag !== 4'd2) begin errors++;
            $display("FAIL st_resume: got cal=%0b tag=%0d required 1/2", cal_signal, tag); end
        tick();
        checks++; if (cal_signal !== 1'b0 || count !== 4'd1) begin errors++;
            $display("FAIL st_ignored_bcast: got cal=%0b count=%0d required 0/1", cal_signal, count); end
        push_exp(4'd9, 32'h55, 32'h3, 4'd7);
        alu_done = 1'b1; alu_tag = 4'd13; alu_value = 32'h55;
        tick(); idle_inputs();
        tick();
        checks++; if (cal_signal !== 1'b1 || lhs !== 32'h55) begin errors++;
            $display("FAIL st_wake: got cal=%0b lhs=%0h required 1/55", cal_signal, lhs); end
        tick();
    endtask

    task automatic test_async_reset();
        drive_dis(4'd1, 1'b1, 4'd12, 32'd0, 1'b0, 4'd0, 32'd0, 4'd1); tick();
        drive_dis(4'd1, 1'b1, 4'd12, 32'd0, 1'b0, 4'd0, 32'd0, 4'd2); tick();
        drive_dis(4'd1, 1'b0, 4'd0, 32'd0, 1'b1, 4'd12, 32'd0, 4'd3); tick();
        drive_dis(4'd2, 1'b0, 4'd0, 32'd6, 1'b0, 4'd0, 32'd6, 4'd4); tick();
        idle_inputs();
        tick();
        checks++; if (cal_signal !== 1'b1 || count !== 4'd3) begin errors++;
            $display("FAIL ar_pre: got cal=%0b count=%0d required 1/3", cal_signal, count); end
        #1 rst_n_in = 1'b0;
        #1;
        checks++; if (cal_signal !== 1'b0 || full !== 1'b0 || count !== 4'd0) begin errors++;
            $display("FAIL ar_async: got cal=%0b full=%0b count=%0d required 0/0/0", cal_signal, full, count); end
        tick(); tick();
        rst_n_in = 1'b1;
        alu_done = 1'b1; alu_tag = 4'd12; alu_value = 32'h9;
        tick(); idle_inputs();
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++; if (cal_signal !== 1'b0 || count !== 4'd0) begin errors++;
                $display("FAIL ar_after%0d: got cal=%0b count=%0d required 0/0", i, cal_signal, count); end
        end
    endtask

    initial begin
        rst_n_in = 1'b0;
        rdy_in = 1'b1;
        idle_inputs();
        dis_opcode = '0; dis_qj_valid = 1'b0; dis_qk_valid = 1'b0;
        dis_qj = '0; dis_qk = '0; dis_vj = '0; dis_vk = '0; dis_tag = '0;
        alu_value = '0; alu_tag = '0; lsb_value = '0; lsb_tag = '0;
        test_reset();
        test_ready_dispatch();
        test_wakeup();
        test_fill_priority();
        test_flush();
        test_stall();
        test_async_reset();
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL missing_issues: got %0d unissued expectations, required 0", exp_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
